// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - state encodings and frame geometry shared by the frame loader and the Sobel FSM
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PAD   = 3'd3,
    ST_DONE  = 3'd4,
    ST_WAIT  = 3'd5
  } state_e;

  function automatic int frame_size(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// rtl/frame_loader_if.sv - upstream pixel stream plus BRAM0 write port seen by the frame loader
interface frame_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  b0_ce0;
  logic                  b0_we0;
  logic [ADDR_WIDTH-1:0] b0_addr0;
  logic [DATA_WIDTH-1:0] b0_d0;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, b0_ce0, b0_we0, b0_addr0, b0_d0
  );
endinterface

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - streams one raster frame into BRAM0 and hands it to the Sobel FSM
// Optional FRAME_LOADER_PAD_EN: zero-fill short frames up to FRAME_SIZE.
module frame_loader
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_idle,
  frame_loader_if.slave         bus,
  output logic                  o_en,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_overflow
);

  localparam int FRAME_SIZE = frame_size(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_CNT  = ADDR_WIDTH'(FRAME_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] num_cnt_q, num_cnt_d;
  logic                  ovf_q, ovf_d;

  logic                  s_ready;
  logic                  accept;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // BRAM0 write is combinational on the accept cycle so pixels land with zero latency
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    num_cnt_d = num_cnt_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    s_ready   = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    accept    = bus.s_valid && s_ready;

    case (state_q)
      ST_IDLE: begin
        if (i_idle) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en    = 1'b1;
          wr_addr  = wr_cnt_q;
          wr_data  = bus.s_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == LAST_ADDR) begin
            num_cnt_d = FULL_CNT;
            if (bus.s_last) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DRAIN;
              ovf_d   = 1'b1;
            end
          end else if (bus.s_last) begin
`ifdef FRAME_LOADER_PAD_EN
            state_d   = ST_PAD;
`else
            state_d   = ST_DONE;
            num_cnt_d = wr_cnt_q + 1'b1;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (accept && bus.s_last) state_d = ST_DONE;
      end
`ifdef FRAME_LOADER_PAD_EN
      ST_PAD: begin
        wr_en    = 1'b1;
        wr_addr  = wr_cnt_q;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == LAST_ADDR) begin
          state_d   = ST_DONE;
          num_cnt_d = FULL_CNT;
        end
      end
`endif
      ST_DONE: begin
        wr_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // downstream has picked up the frame once it leaves idle
        if (!i_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      num_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      num_cnt_q <= num_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.b0_ce0   = wr_en;
  assign bus.b0_we0   = wr_en;
  assign bus.b0_addr0 = wr_addr;
  assign bus.b0_d0    = wr_data;
  assign o_en         = (state_q == ST_DONE);
  assign o_num_cnt    = num_cnt_q;
  assign o_overflow   = ovf_q;

endmodule
